req_vector_encoder: RTL and testbench



---
 rtl/req_enc_pkg.sv | 17 +
 rtl/lsb_priority_enc.sv | 26 ++
 rtl/req_vector_encoder.sv | 96 +++++++++
 tb/tb_req_vector_encoder.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/req_enc_pkg.sv
// Shared types and helpers for the request-vector encoder.
// Holds the FSM state enum, the default request width and the index-width helper.
package req_enc_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } state_e;

   localparam int DEFAULT_N = 4;

   // Floors at 1 so that the index port is always at least one bit wide.
   function automatic int idx_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/lsb_priority_enc.sv
// Combinational lowest-set-bit priority encoder.
// Reports the lowest set index, whether any bit is set, and whether exactly one bit is set.
module lsb_priority_enc #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  vec,
   output logic [IW-1:0] idx,
   output logic          any,
   output logic          single
);

   logic [N-1:0] vec_m1;

   always_comb begin
      idx    = '0;
      vec_m1 = vec - {{(N-1){1'b0}}, 1'b1};
      any    = |vec;
      // Clearing the lowest set bit leaves zero only for a one-hot vector.
      single = any && ((vec & vec_m1) == '0);
      for (int i = N - 1; i >= 0; i--) begin
         if (vec[i]) idx = IW'(i);
      end
   end

endmodule

// File: rtl/req_vector_encoder.sv
// Sequential N-to-log2(N) encoder: latches a request vector, then emits each set index lowest first.
// Optional REQ_ENC_ONEHOT_CHECK_EN adds a sticky err_multi flag for accepted multi-hot vectors.
module req_vector_encoder
   import req_enc_pkg::*;
#(
   parameter  int N  = DEFAULT_N,
   localparam int IW = idx_width(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N-1:0]  in_vec,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [IW-1:0] out_idx,
   output logic          out_last
`ifdef REQ_ENC_ONEHOT_CHECK_EN
   ,
   output logic          err_multi
`endif
);

   state_e        state_q, state_d;
   logic [N-1:0]  pending_q, pending_d;
   logic [N-1:0]  pending_m1;
   logic [IW-1:0] pe_idx;
   logic          pe_any;
   logic          pe_single;

   lsb_priority_enc #(
      .N  (N),
      .IW (IW)
   ) u_pe (
      .vec    (pending_q),
      .idx    (pe_idx),
      .any    (pe_any),
      .single (pe_single)
   );

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DRAIN) && pe_any;
   assign out_idx   = pe_idx;
   assign out_last  = pe_single;

   always_comb begin
      state_d    = state_q;
      pending_d  = pending_q;
      pending_m1 = pending_q - {{(N-1){1'b0}}, 1'b1};
      case (state_q)
         IDLE: begin
            // An all-zero vector is consumed by the handshake but produces nothing.
            if (in_valid && (in_vec != '0)) begin
               pending_d = in_vec;
               state_d   = DRAIN;
            end
         end
         DRAIN: begin
            if (out_ready) begin
               pending_d = pending_q & pending_m1;
               if (pe_single) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
      end
   end

`ifdef REQ_ENC_ONEHOT_CHECK_EN
   logic         err_multi_q, err_multi_d;
   logic [N-1:0] in_vec_m1;

   always_comb begin
      in_vec_m1   = in_vec - {{(N-1){1'b0}}, 1'b1};
      err_multi_d = err_multi_q;
      if (in_ready && in_valid && ((in_vec & in_vec_m1) != '0)) err_multi_d = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) err_multi_q <= 1'b0;
      else     err_multi_q <= err_multi_d;
   end

   assign err_multi = err_multi_q;
`endif

endmodule

// File: tb/tb_req_vector_encoder.sv
// Bench for req_vector_encoder: queue-based reference model checked every cycle, plus literal checks.
// Inputs change and outputs are compared on the falling clock edge.
module tb_req_vector_encoder;

   localparam int N  = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [N-1:0]  in_vec;
   logic          out_valid;
   logic          out_ready;
   logic [IW-1:0] out_idx;
   logic          out_last;
`ifdef REQ_ENC_ONEHOT_CHECK_EN
   logic          err_multi;
`endif

   int errors = 0;
   int checks = 0;
   int ncyc   = 0;

   // Reference model: the indices still owed to the consumer, lowest first.
   int exp_q[$];
   bit exp_err = 1'b0;

   req_vector_encoder #(.N(N)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_vec    (in_vec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_idx   (out_idx),
      .out_last  (out_last)
`ifdef REQ_ENC_ONEHOT_CHECK_EN
      ,
      .err_multi (err_multi)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      ncyc++;
      if (rst) begin
         exp_q.delete();
         exp_err = 1'b0;
      end else if (exp_q.size() == 0) begin
         if (in_valid) begin
            for (int i = 0; i < N; i++) if (in_vec[i]) exp_q.push_back(i);
            if ($countones(in_vec) > 1) exp_err = 1'b1;
         end
      end else if (out_ready) begin
         void'(exp_q.pop_front());
      end
   end

   always @(negedge clk) begin
      if (ncyc > 0) begin
         check("model in_ready", int'(in_ready), int'(exp_q.size() == 0));
         check("model out_valid", int'(out_valid), int'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            check("model out_idx", int'(out_idx), exp_q[0]);
            check("model out_last", int'(out_last), int'(exp_q.size() == 1));
         end
`ifdef REQ_ENC_ONEHOT_CHECK_EN
         check("model err_multi", int'(err_multi), int'(exp_err));
`endif
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic send(input logic [N-1:0] v);
      in_valid = 1'b1;
      in_vec   = v;
      cyc();
      in_valid = 1'b0;
      in_vec   = '0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_vec = '0; out_ready = 1'b1;
      cyc(2);
      check("reset in_ready", int'(in_ready), 1);
      check("reset out_valid", int'(out_valid), 0);
      check("reset out_idx", int'(out_idx), 0);
      check("reset out_last", int'(out_last), 0);
      rst = 1'b0;

      // One-hot 0100
      send(4'b0100);
      check("onehot valid", int'(out_valid), 1);
      check("onehot idx", int'(out_idx), 2);
      check("onehot last", int'(out_last), 1);
      check("onehot in_ready low", int'(in_ready), 0);
      cyc();
      check("onehot bubble in_ready", int'(in_ready), 1);
      check("onehot done valid", int'(out_valid), 0);

      // Multi-hot 1011 -> 0,1,3
      send(4'b1011);
      check("multi idx0", int'(out_idx), 0);
      check("multi last0", int'(out_last), 0);
      check("multi rdy0", int'(in_ready), 0);
      cyc();
      check("multi idx1", int'(out_idx), 1);
      check("multi last1", int'(out_last), 0);
      check("multi rdy1", int'(in_ready), 0);
      cyc();
      check("multi idx3", int'(out_idx), 3);
      check("multi last3", int'(out_last), 1);
      check("multi rdy3", int'(in_ready), 0);
      cyc();
      check("multi rdy end", int'(in_ready), 1);

      // Backpressure 0110; a competing vector offered during DRAIN must be ignored
      out_ready = 1'b0;
      send(4'b0110);
      in_valid = 1'b1; in_vec = 4'b1000;
      for (int i = 0; i < 5; i++) begin
         check("bp hold idx", int'(out_idx), 1);
         check("bp hold valid", int'(out_valid), 1);
         cyc();
      end
      in_valid = 1'b0; in_vec = '0;
      out_ready = 1'b1;
      check("bp release idx1", int'(out_idx), 1);
      cyc();
      check("bp release idx2", int'(out_idx), 2);
      check("bp release last", int'(out_last), 1);
      cyc();
      check("bp done rdy", int'(in_ready), 1);

      // Zero vector
      send(4'b0000);
      check("zero in_ready", int'(in_ready), 1);
      check("zero out_valid", int'(out_valid), 0);
      cyc();
      check("zero out_valid later", int'(out_valid), 0);

      // Reset mid-drain
      send(4'b1111);
      check("rstmid idx0", int'(out_idx), 0);
      cyc();
      check("rstmid idx1", int'(out_idx), 1);
      rst = 1'b1;
      cyc();
      rst = 1'b0;
      check("rstmid valid", int'(out_valid), 0);
      check("rstmid in_ready", int'(in_ready), 1);
      send(4'b1000);
      check("after rst idx3", int'(out_idx), 3);
      check("after rst last", int'(out_last), 1);
      cyc();
      check("after rst done", int'(out_valid), 0);

`ifdef REQ_ENC_ONEHOT_CHECK_EN
      rst = 1'b1; cyc(); rst = 1'b0;
      send(4'b0001);
      cyc();
      check("err onehot", int'(err_multi), 0);
      send(4'b0011);
      check("err set", int'(err_multi), 1);
      cyc(3);
      check("err sticky", int'(err_multi), 1);
      rst = 1'b1; cyc(); rst = 1'b0;
      check("err cleared", int'(err_multi), 0);
`endif

      cyc(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
